ysyx_23060203_idu: RTL and testbench

YSYX_23060203_IDU -- requirements
Module: ysyx_23060203_IDU

---
 rtl/ysyx_23060203_idu.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ysyx_23060203_idu.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_idu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_23060203_idu : single-entry RV32I decode stage with hazard stall and  |
// |                     branch/jump resolution.                                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ysyx_23060203_idu (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    output logic        in_ready,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic [4:0]  gpr_raddr1,
    output logic [4:0]  gpr_raddr2,
    input  logic [31:0] gpr_rdata1,
    input  logic [31:0] gpr_rdata2,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    input  logic [4:0]  exu_rd,
    input  logic [4:0]  wbu_rd,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_val_a,
    output logic [31:0] out_val_b,
    output logic [31:0] out_val_c,
    output logic [2:0]  out_alu_funct,
    output logic        out_alu_sw,
    output logic [4:0]  out_rd,
    output logic        out_rd_src,
    output logic [3:0]  out_ls,
    output logic        out_csr_wen,
    output logic        out_csr_src,
    output logic        out_exc,
    output logic        out_ret,
    output logic        out_fencei
);

    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_MISC   = 7'b0001111;
    localparam logic [6:0]  c_OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] c_INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] c_INST_MRET   = 32'h3020_0073;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_csr_src;
    logic        w_ill, w_rs1_used, w_rs2_used, w_taken, w_cond;
    logic        w_stall, w_out_fire, w_load;

    assign w_opcode = r_inst[6:0];
    assign w_funct3 = r_inst[14:12];
    assign w_funct7 = r_inst[31:25];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_rd     = r_inst[11:7];

    assign w_imm_i = {{20{r_inst[31]}}, r_inst[31:20]};
    assign w_imm_s = {{20{r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
    assign w_imm_b = {{19{r_inst[31]}}, r_inst[31], r_inst[7], r_inst[30:25], r_inst[11:8], 1'b0};
    assign w_imm_u = {r_inst[31:12], 12'b0};
    assign w_imm_j = {{11{r_inst[31]}}, r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0};

    assign gpr_raddr1 = w_rs1;
    assign gpr_raddr2 = w_rs2;
    assign csr_raddr  = r_inst[31:20];
    assign out_pc     = r_pc;
    assign w_csr_src  = w_funct3[2] ? {27'b0, w_rs1} : gpr_rdata1;

    always_comb begin
        w_cond = 1'b0;
        case (w_funct3)
            3'b000:  w_cond = (gpr_rdata1 == gpr_rdata2);
            3'b001:  w_cond = (gpr_rdata1 != gpr_rdata2);
            3'b100:  w_cond = ($signed(gpr_rdata1) <  $signed(gpr_rdata2));
            3'b101:  w_cond = ($signed(gpr_rdata1) >= $signed(gpr_rdata2));
            3'b110:  w_cond = (gpr_rdata1 <  gpr_rdata2);
            3'b111:  w_cond = (gpr_rdata1 >= gpr_rdata2);
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_ill         = 1'b0;
        w_rs1_used    = 1'b0;
        w_rs2_used    = 1'b0;
        w_taken       = 1'b0;
        redirect_pc   = r_pc + w_imm_b;
        out_val_a     = 32'b0;
        out_val_b     = 32'b0;
        out_val_c     = 32'b0;
        out_alu_funct = w_funct3;
        out_alu_sw    = 1'b0;
        out_rd        = w_rd;
        out_rd_src    = 1'b0;
        out_ls        = 4'b0000;
        out_csr_wen   = 1'b0;
        out_csr_src   = 1'b0;
        out_exc       = 1'b0;
        out_ret       = 1'b0;
        out_fencei    = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                out_val_a     = w_imm_u;
                out_rd_src    = 1'b1;
                out_alu_funct = 3'b000;
            end
            c_OPC_AUIPC: begin
                out_val_a     = r_pc;
                out_val_b     = w_imm_u;
                out_alu_funct = 3'b000;
            end
            c_OPC_JAL: begin
                out_val_a     = r_pc + 32'd4;
                out_rd_src    = 1'b1;
                out_alu_funct = 3'b000;
                w_taken       = 1'b1;
                redirect_pc   = r_pc + w_imm_j;
            end
            c_OPC_JALR: begin
                if (w_funct3 != 3'b000) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a     = r_pc + 32'd4;
                    out_rd_src    = 1'b1;
                    out_alu_funct = 3'b000;
                    w_rs1_used    = 1'b1;
                    w_taken       = 1'b1;
                    redirect_pc   = (gpr_rdata1 + w_imm_i) & ~32'd1;
                end
            end
            c_OPC_BRANCH: begin
                if (w_funct3[2:1] == 2'b01) begin
                    w_ill = 1'b1;
                end else begin
                    out_rd     = 5'd0;
                    w_rs1_used = 1'b1;
                    w_rs2_used = 1'b1;
                    w_taken    = w_cond;
                end
            end
            c_OPC_LOAD: begin
                if (w_funct3 == 3'b011 || w_funct3[2:1] == 2'b11) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a     = gpr_rdata1;
                    out_val_b     = w_imm_i;
                    out_ls        = {1'b1, w_funct3};
                    out_alu_funct = 3'b000;
                    w_rs1_used    = 1'b1;
                end
            end
            c_OPC_STORE: begin
                if (w_funct3[2] || w_funct3[1:0] == 2'b11) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a     = gpr_rdata1;
                    out_val_b     = w_imm_s;
                    out_val_c     = gpr_rdata2;
                    out_ls        = {2'b01, w_funct3[1:0]};
                    out_alu_funct = 3'b000;
                    out_rd        = 5'd0;
                    w_rs1_used    = 1'b1;
                    w_rs2_used    = 1'b1;
                end
            end
            c_OPC_OPIMM: begin
                // Shift-immediates carry funct7 in the immediate field; only SRAI may set bit 5.
                if ((w_funct3 == 3'b001 && w_funct7 != 7'b0000000) ||
                    (w_funct3 == 3'b101 && w_funct7 != 7'b0000000 && w_funct7 != 7'b0100000)) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a  = gpr_rdata1;
                    out_val_b  = w_imm_i;
                    out_alu_sw = (w_funct3 == 3'b101) & w_funct7[5];
                    w_rs1_used = 1'b1;
                end
            end
            c_OPC_OP: begin
                if (!(w_funct7 == 7'b0000000 ||
                      (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)))) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a  = gpr_rdata1;
                    out_val_b  = gpr_rdata2;
                    out_alu_sw = w_funct7[5];
                    w_rs1_used = 1'b1;
                    w_rs2_used = 1'b1;
                end
            end
            c_OPC_MISC: begin
                out_rd = 5'd0;
                if (w_funct3 == 3'b001)
                    out_fencei = 1'b1;
                else if (w_funct3 != 3'b000)
                    w_ill = 1'b1;
            end
            c_OPC_SYSTEM: begin
                if (w_funct3 == 3'b000) begin
                    out_rd = 5'd0;
                    if (r_inst == c_INST_ECALL || r_inst == c_INST_EBREAK)
                        out_exc = 1'b1;
                    else if (r_inst == c_INST_MRET)
                        out_ret = 1'b1;
                    else
                        w_ill = 1'b1;
                end else if (w_funct3 == 3'b100) begin
                    w_ill = 1'b1;
                end else begin
                    out_val_a   = csr_rdata;
                    out_val_c   = {20'b0, r_inst[31:20]};
                    out_rd_src  = 1'b1;
                    out_csr_wen = 1'b1;
                    w_rs1_used  = ~w_funct3[2];
                    case (w_funct3[1:0])
                        2'b01: begin
                            out_csr_src = 1'b1;
                            out_val_b   = w_csr_src;
                        end
                        2'b10: begin
                            out_alu_funct = 3'b110;
                            out_val_b     = w_csr_src;
                        end
                        default: begin
                            out_alu_funct = 3'b111;
                            out_val_b     = ~w_csr_src;
                        end
                    endcase
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            out_exc    = 1'b1;
            out_rd     = 5'd0;
            out_ls     = 4'b0000;
            out_rd_src = 1'b0;
        end
    end

    assign w_stall = (w_rs1_used && w_rs1 != 5'd0 && (w_rs1 == exu_rd || w_rs1 == wbu_rd)) ||
                     (w_rs2_used && w_rs2 != 5'd0 && (w_rs2 == exu_rd || w_rs2 == wbu_rd));

    assign out_valid      = r_valid & ~flush & ~w_stall;
    assign w_out_fire     = out_valid & out_ready;
    assign redirect_valid = w_out_fire & w_taken;
    assign in_ready       = (~r_valid | w_out_fire) & ~redirect_valid & ~flush;
    assign w_load         = in_ready & in_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= 32'b0;
            r_inst  <= 32'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_inst  <= in_inst;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_idu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx_23060203_idu : directed self-checking bench for the decode stage.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ysyx_23060203_idu;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_ready, in_valid;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  gpr_raddr1, gpr_raddr2;
    logic [31:0] gpr_rdata1, gpr_rdata2;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [4:0]  exu_rd, wbu_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready, out_valid;
    logic [31:0] out_pc, out_val_a, out_val_b, out_val_c;
    logic [2:0]  out_alu_funct;
    logic        out_alu_sw;
    logic [4:0]  out_rd;
    logic        out_rd_src;
    logic [3:0]  out_ls;
    logic        out_csr_wen, out_csr_src, out_exc, out_ret, out_fencei;

    logic [31:0] regs [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    assign gpr_rdata1 = regs[gpr_raddr1];
    assign gpr_rdata2 = regs[gpr_raddr2];
    assign csr_rdata  = (csr_raddr == 12'h300) ? 32'h0000_1888 : 32'h0;

    ysyx_23060203_idu dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_ready(in_ready), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .gpr_raddr1(gpr_raddr1), .gpr_raddr2(gpr_raddr2),
        .gpr_rdata1(gpr_rdata1), .gpr_rdata2(gpr_rdata2),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .exu_rd(exu_rd), .wbu_rd(wbu_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_val_a(out_val_a), .out_val_b(out_val_b), .out_val_c(out_val_c),
        .out_alu_funct(out_alu_funct), .out_alu_sw(out_alu_sw), .out_rd(out_rd),
        .out_rd_src(out_rd_src), .out_ls(out_ls), .out_csr_wen(out_csr_wen),
        .out_csr_src(out_csr_src), .out_exc(out_exc), .out_ret(out_ret),
        .out_fencei(out_fencei)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h0000_0011;
        regs[4] = 32'h0000_0008;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h0; in_inst = 32'h0;
        exu_rd = 5'd0; wbu_rd = 5'd0; out_ready = 1'b0;

        @(negedge clock);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        adv();
        reset = 1'b0;

        // addi x1,x0,5; wbu_rd matches the unused rs2 field and x0 matches exu_rd=0
        feed(32'h8000_0000, 32'h0050_0093);
        wbu_rd = 5'd5;
        @(negedge clock);
        chk("addi_accept", {31'b0, in_ready}, 32'd1);
        adv();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_pc", out_pc, 32'h8000_0000);
        chk("addi_val_a", out_val_a, 32'd0);
        chk("addi_val_b", out_val_b, 32'd5);
        chk("addi_funct", {29'b0, out_alu_funct}, 32'd0);
        chk("addi_rd", {27'b0, out_rd}, 32'd1);
        adv();
        wbu_rd = 5'd0;

        // add x2,x1,x1 stalled by exu_rd=1 for three cycles
        feed(32'h8000_0004, 32'h0010_8133);
        @(negedge clock);
        chk("add_idle_after_fire", {31'b0, out_valid}, 32'd0);
        adv();
        in_valid = 1'b0; exu_rd = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("add_stall_valid", {31'b0, out_valid}, 32'd0);
            chk("add_stall_ready", {31'b0, in_ready}, 32'd0);
            adv();
        end
        exu_rd = 5'd0;
        @(negedge clock);
        chk("add_valid", {31'b0, out_valid}, 32'd1);
        chk("add_val_a", out_val_a, 32'h11);
        chk("add_val_b", out_val_b, 32'h11);
        chk("add_rd", {27'b0, out_rd}, 32'd2);
        chk("add_sw", {31'b0, out_alu_sw}, 32'd0);
        adv();

        // beq x0,x0,+16: redirect and block the competing input
        out_ready = 1'b0;
        feed(32'h8000_0010, 32'h0000_0863);
        adv();
        feed(32'h8000_0014, 32'h0050_0093);
        out_ready = 1'b1;
        @(negedge clock);
        chk("beq_valid", {31'b0, out_valid}, 32'd1);
        chk("beq_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("beq_target", redirect_pc, 32'h8000_0020);
        chk("beq_in_ready", {31'b0, in_ready}, 32'd0);
        chk("beq_rd", {27'b0, out_rd}, 32'd0);
        adv();
        in_valid = 1'b0;
        @(negedge clock);
        chk("beq_not_loaded", {31'b0, out_valid}, 32'd0);
        chk("beq_ready_after", {31'b0, in_ready}, 32'd1);

        // bne x0,x0,+16: not taken
        feed(32'h8000_0030, 32'h0000_1863);
        adv();
        in_valid = 1'b0;
        @(negedge clock);
        chk("bne_valid", {31'b0, out_valid}, 32'd1);
        chk("bne_redirect", {31'b0, redirect_valid}, 32'd0);
        adv();

        // jal x1,-8 at 0x80000100
        feed(32'h8000_0100, 32'hFF9F_F0EF);
        adv();
        in_valid = 1'b0;
        @(negedge clock);
        chk("jal_val_a", out_val_a, 32'h8000_0104);
        chk("jal_rd_src", {31'b0, out_rd_src}, 32'd1);
        chk("jal_rd", {27'b0, out_rd}, 32'd1);
        chk("jal_redirect", {31'b0, redirect_valid}, 32'd1);
        chk("jal_target", redirect_pc, 32'h8000_00F8);
        adv();

        // csrrc x3,mstatus,x4
        feed(32'h8000_0200, 32'h3002_31F3);
        adv();
        in_valid = 1'b0;
        @(negedge clock);
        chk("csr_raddr", {20'b0, csr_raddr}, 32'h300);
        chk("csr_val_a", out_val_a, 32'h0000_1888);
        chk("csr_val_b", out_val_b, 32'hFFFF_FFF7);
        chk("csr_val_c", out_val_c, 32'h300);
        chk("csr_funct", {29'b0, out_alu_funct}, 32'd7);
        chk("csr_wen", {31'b0, out_csr_wen}, 32'd1);
        chk("csr_src", {31'b0, out_csr_src}, 32'd0);
        chk("csr_rd", {27'b0, out_rd}, 32'd3);
        chk("csr_rd_src", {31'b0, out_rd_src}, 32'd1);
        adv();

        // lw x5,4(x1) held, then flushed
        out_ready = 1'b0;
        feed(32'h8000_0300, 32'h0040_A283);
        adv();
        in_valid = 1'b0;
        @(negedge clock);
        chk("lw_valid", {31'b0, out_valid}, 32'd1);
        chk("lw_ls", {28'b0, out_ls}, 32'hA);
        chk("lw_val_a", out_val_a, 32'h11);
        chk("lw_val_b", out_val_b, 32'd4);
        adv();
        flush = 1'b1;
        @(negedge clock);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        adv();
        flush = 1'b0;
        @(negedge clock);
        chk("post_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("post_flush_ready", {31'b0, in_ready}, 32'd1);

        // all-ones encoding is illegal
        feed(32'h8000_0400, 32'hFFFF_FFFF);
        adv();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_pc", out_pc, 32'h8000_0400);
        chk("ill_exc", {31'b0, out_exc}, 32'd1);
        chk("ill_rd", {27'b0, out_rd}, 32'd0);
        chk("ill_ls", {28'b0, out_ls}, 32'd0);
        adv();

        // reset asserted mid-stall drops the held instruction at once
        feed(32'h8000_0500, 32'h0010_8133);
        adv();
        in_valid = 1'b0; exu_rd = 5'd1;
        @(negedge clock);
        chk("mid_stall_valid", {31'b0, out_valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
        chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
        adv();
        reset = 1'b0; exu_rd = 5'd0;
        @(negedge clock);
        chk("rst_dropped", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
